// File: rtl/dice_roll_if.sv
// Button-in / face-out signal bundle between the board-side logic and the dice roll sequencer.
// The controller connects through the slave modport.
interface dice_roll_if;
    logic       i_Roll;
    logic [2:0] o_Number;
    logic       o_Rolling;
    logic       o_Done;

    modport master (output i_Roll, input o_Number, input o_Rolling, input o_Done);
    modport slave  (input i_Roll, output o_Number, output o_Rolling, output o_Done);
endinterface

// File: rtl/dice_roll_controller.sv
// Dice roll sequencer: synchronizes and debounces the push-button, then steps the face
// value fast, slows it down linearly, and finally holds the result with a one-cycle done pulse.
module dice_roll_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FAST_TICKS      = 1500000,
    parameter int ROLL_STEPS      = 12,
    parameter int SLOW_STEPS      = 6
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    dice_roll_if.slave  bus
);
    localparam int TW   = $clog2(FAST_TICKS * (SLOW_STEPS + 1) + 1);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int MAXS = (ROLL_STEPS > SLOW_STEPS) ? ROLL_STEPS : SLOW_STEPS;
    localparam int SW   = $clog2(MAXS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ROLLING, S_SLOWING, S_SHOW} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic            deb_q, deb_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [2:0]      seed_q, seed_d;
    logic [2:0]      number_q, number_d;
    logic            rolling_q, rolling_d;
    logic            done_q, done_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [SW-1:0]   step_q, step_d;

    logic            press;
    logic            tick_fire;
    logic [TW-1:0]   period;
    logic [2:0]      number_step;

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[0], bus.i_Roll};
        deb_d     = deb_q;
        deb_cnt_d = '0;
        number_d  = number_q;
        done_d    = 1'b0;
        tick_d    = tick_q;
        step_d    = step_q;
        seed_d    = (seed_q == 3'd6) ? 3'd1 : seed_q + 3'd1;

        // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        if (sync_q[1] != deb_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
        press = !deb_q && deb_d;

        number_step = (number_q == 3'd6) ? 3'd1 : number_q + 3'd1;
        if (state_q == S_SLOWING) begin
            period = TW'(FAST_TICKS) * (TW'(step_q) + TW'(2));
        end else begin
            period = TW'(FAST_TICKS);
        end
        tick_fire = (tick_q == period - TW'(1));

        case (state_q)
            S_IDLE, S_SHOW: begin
                if (press) begin
                    number_d = seed_q;
                    tick_d   = '0;
                    step_d   = '0;
                    state_d  = S_ROLLING;
                end
            end
            S_ROLLING: begin
                if (tick_fire) begin
                    number_d = number_step;
                    tick_d   = '0;
                    if (step_q == SW'(ROLL_STEPS - 1)) begin
                        step_d  = '0;
                        state_d = S_SLOWING;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_SLOWING: begin
                if (tick_fire) begin
                    number_d = number_step;
                    tick_d   = '0;
                    if (step_q == SW'(SLOW_STEPS - 1)) begin
                        step_d  = '0;
                        state_d = S_SHOW;
                        done_d  = 1'b1;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        rolling_d = (state_d == S_ROLLING) || (state_d == S_SLOWING);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            sync_q    <= '0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            seed_q    <= 3'd1;
            number_q  <= 3'd0;
            rolling_q <= 1'b0;
            done_q    <= 1'b0;
            tick_q    <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            seed_q    <= seed_d;
            number_q  <= number_d;
            rolling_q <= rolling_d;
            done_q    <= done_d;
            tick_q    <= tick_d;
            step_q    <= step_d;
        end
    end

    assign bus.o_Number  = number_q;
    assign bus.o_Rolling = rolling_q;
    assign bus.o_Done    = done_q;
endmodule
